iod_delay_line_ctrl: RTL and testbench
======================================

IOD_DELAY_LINE_CTRL -- requirements
Module: iod_delay_line_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter MOVE_GAP, default 4, SHALL set the cycle spacing between DELAY_LINE_MOVE_0 pulses (legal 2..15).
REQ-003 Parameter LOAD_VAL, default 8'd1, SHALL set the tap position the delay line holds after a load.
REQ-004 FAB_CLK  input  1  fabric clock; all logic is on its rising edge.
REQ-005 ARST  input  1  asynchronous reset, active-high.
REQ-006 CMD_VALID  input  1  command request.
REQ-007 CMD_READY  output  1  command accepted when CMD_VALID and CMD_READY are both high.
REQ-008 CMD_OP  input  2  00 load, 01 step up, 10 step down, 11 reserved.
REQ-009 CMD_STEPS  input  8  tap count for step ops, 0..255.
REQ-010 BUSY  output  1  high whenever the state is not IDLE.
REQ-011 DONE  output  1  one-cycle command-completion pulse.
REQ-012 ERR  output  1  one-cycle error flag, valid only with DONE.
REQ-013 DELAY_LINE_MOVE_0  output  1  IOD tap-move strobe.
REQ-014 DELAY_LINE_DIRECTION_0  output  1  IOD direction: 1 = up, 0 = down.
REQ-015 DELAY_LINE_LOAD_0  output  1  IOD load strobe.
REQ-016 DELAY_LINE_OUT_OF_RANGE_0  input  1  IOD out-of-range status.
REQ-017 TAP_POS  output  8  tracked tap position; behaviour per REQ-035 and REQ-036.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, SETUP, MOVE, GAP and FIN.
REQ-019 CMD_READY SHALL be high only in IDLE.
REQ-020 CMD_OP, CMD_STEPS and the direction SHALL be registered on the accept cycle T.
REQ-021 Load: IDLE->LOAD->FIN, with DELAY_LINE_LOAD_0 high for exactly cycle T+1 and DONE=1 at T+2.
REQ-022 Step, N>0, IDLE->SETUP: DELAY_LINE_DIRECTION_0 SHALL be driven from T+1 and held until FIN.
REQ-023 Step, N>0: MOVE pulses SHALL occur at T+2+k*MOVE_GAP for k = 0..N-1, each one cycle wide, with the state going MOVE->GAP for MOVE_GAP-1 cycles and then back to MOVE while steps remain.
REQ-024 Step, N>0: DONE SHALL assert at T+2+N*MOVE_GAP.
REQ-025 A step op with N=0 SHALL go IDLE->FIN with DONE at T+1, ERR=0 and no MOVE pulse.
REQ-026 Reserved op 11 SHALL go IDLE->FIN with DONE=1 and ERR=1 at T+1 and drive no IOD strobe.
REQ-027 DELAY_LINE_OUT_OF_RANGE_0 SHALL be registered once; the registered value high in any GAP cycle SHALL abort remaining steps and enter FIN next cycle with DONE=1 and ERR=1.
REQ-028 Out-of-range high in IDLE, LOAD or SETUP SHALL be ignored.
REQ-029 FIN SHALL last one cycle and return to IDLE, so a new command can be accepted at FIN+1 and back-to-back commands have one idle cycle between them.
REQ-030 The remaining-step counter SHALL be 8 bits, decrement on each MOVE, and never wrap.
REQ-031 DELAY_LINE_MOVE_0 and DELAY_LINE_LOAD_0 SHALL never be high in the same cycle.

Reset
REQ-032 On ARST high, the state SHALL go to IDLE immediately, without waiting for a clock edge.
REQ-033 Reset SHALL drive these output values: CMD_READY=1 after release, BUSY=0, DONE=0, ERR=0, MOVE=0, LOAD=0, DIRECTION=0, TAP_POS=LOAD_VAL.
REQ-034 Reset mid-command SHALL discard the command, with no DONE issued for it.

Configuration
REQ-035 With IOD_DLY_TAP_TRACK_EN defined, TAP_POS SHALL be set to LOAD_VAL on LOAD, increment on each up MOVE (saturating at 255), and decrement on each down MOVE (saturating at 0).
REQ-036 With IOD_DLY_TAP_TRACK_EN defined, a step whose next MOVE would cross 0 or 255 SHALL abort before that MOVE with DONE=1 and ERR=1.
REQ-037 Without IOD_DLY_TAP_TRACK_EN, TAP_POS SHALL be constant 0 and no saturation abort SHALL exist.

Verification
REQ-038 Load, accepted at T -> LOAD high at T+1 only, DONE=1/ERR=0 at T+2, TAP_POS=1 when tracking is enabled.
REQ-039 Step up, N=3, MOVE_GAP=4, accepted at T -> DIRECTION=1 from T+1, MOVE at T+2, T+6 and T+10, DONE at T+14, TAP_POS=4 when tracking is enabled.
REQ-040 Step down, N=5, with OUT_OF_RANGE forced high after the 2nd MOVE -> exactly 2 MOVE pulses, DONE=1 and ERR=1.
REQ-041 CMD_STEPS=0 and op 11 -> DONE at T+1 with ERR=0 and ERR=1 respectively, and zero MOVE/LOAD pulses.
REQ-042 ARST asserted between the 1st and 2nd MOVE of N=4 -> outputs at reset values asynchronously, no DONE, next command accepted normally.
REQ-043 Tracking enabled, TAP_POS=254, step up N=3 -> 1 MOVE, TAP_POS=255, DONE=1 and ERR=1.

Source files
------------

// File: rtl/iod_delay_line_ctrl_if.sv
// Command handshake and status bundle for iod_delay_line_ctrl.
// The controller connects to the slave modport; the command issuer connects to master.
interface iod_delay_line_ctrl_if;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [1:0] CMD_OP;
  logic [7:0] CMD_STEPS;
  logic       BUSY;
  logic       DONE;
  logic       ERR;
  logic [7:0] TAP_POS;

  modport master (
    output CMD_VALID, CMD_OP, CMD_STEPS,
    input  CMD_READY, BUSY, DONE, ERR, TAP_POS
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_STEPS,
    output CMD_READY, BUSY, DONE, ERR, TAP_POS
  );
endinterface

// File: rtl/iod_delay_line_ctrl.sv
// IOD delay-line controller: load / step-up / step-down commands with spaced tap-move strobes.
// Optional tap tracking with saturation abort is enabled by defining IOD_DLY_TAP_TRACK_EN.
module iod_delay_line_ctrl #(
  parameter int unsigned MOVE_GAP = 4,
  parameter logic [7:0]  LOAD_VAL = 8'd1
) (
  input  logic                  FAB_CLK,
  input  logic                  ARST,
  iod_delay_line_ctrl_if.slave  cmd,
  output logic                  DELAY_LINE_MOVE_0,
  output logic                  DELAY_LINE_DIRECTION_0,
  output logic                  DELAY_LINE_LOAD_0,
  input  logic                  DELAY_LINE_OUT_OF_RANGE_0
);

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, MOVE, GAP, FIN} state_t;

  // GAP lasts MOVE_GAP-1 cycles; the counter holds the cycles left after the current one.
  localparam logic [3:0] GAP_RELOAD = 4'(MOVE_GAP - 2);

  state_t     state;
  logic       ready_q;
  logic       busy_q;
  logic       done_q;
  logic       err_q;
  logic       move_q;
  logic       load_q;
  logic       dir_q;
  logic       oor_q;
  logic [7:0] steps_left;
  logic [3:0] gap_cnt;
  logic       sat_hit;

`ifdef IOD_DLY_TAP_TRACK_EN
  logic [7:0] tap_q;

  // The next move in the latched direction would push the tap past an end stop.
  assign sat_hit     = dir_q ? (tap_q == 8'hFF) : (tap_q == 8'h00);
  assign cmd.TAP_POS = tap_q;
`else
  logic unused_load_val;

  assign sat_hit         = 1'b0;
  assign cmd.TAP_POS     = '0;
  assign unused_load_val = ^LOAD_VAL;
`endif

  assign cmd.CMD_READY              = ready_q;
  assign cmd.BUSY                   = busy_q;
  assign cmd.DONE                   = done_q;
  assign cmd.ERR                    = err_q;
  assign DELAY_LINE_MOVE_0          = move_q;
  assign DELAY_LINE_LOAD_0          = load_q;
  assign DELAY_LINE_DIRECTION_0     = dir_q;

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state      <= IDLE;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      move_q     <= 1'b0;
      load_q     <= 1'b0;
      dir_q      <= 1'b0;
      oor_q      <= 1'b0;
      steps_left <= '0;
      gap_cnt    <= '0;
`ifdef IOD_DLY_TAP_TRACK_EN
      tap_q      <= LOAD_VAL;
`endif
    end else begin
      oor_q  <= DELAY_LINE_OUT_OF_RANGE_0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      move_q <= 1'b0;
      load_q <= 1'b0;

      unique case (state)
        IDLE: begin
          if (cmd.CMD_VALID) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            case (cmd.CMD_OP)
              2'b00: begin
                state  <= LOAD;
                load_q <= 1'b1;
              end
              2'b01, 2'b10: begin
                dir_q      <= (cmd.CMD_OP == 2'b01);
                steps_left <= cmd.CMD_STEPS;
                if (cmd.CMD_STEPS == '0) begin
                  state  <= FIN;
                  done_q <= 1'b1;
                end else begin
                  state <= SETUP;
                end
              end
              default: begin
                state  <= FIN;
                done_q <= 1'b1;
                err_q  <= 1'b1;
              end
            endcase
          end
        end

        LOAD: begin
          state  <= FIN;
          done_q <= 1'b1;
`ifdef IOD_DLY_TAP_TRACK_EN
          tap_q  <= LOAD_VAL;
`endif
        end

        SETUP: begin
          if (sat_hit) begin
            state  <= FIN;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else begin
            state  <= MOVE;
            move_q <= 1'b1;
          end
        end

        MOVE: begin
          state   <= GAP;
          gap_cnt <= GAP_RELOAD;
          if (steps_left != '0) steps_left <= steps_left - 8'd1;
`ifdef IOD_DLY_TAP_TRACK_EN
          if (dir_q) begin
            if (tap_q != 8'hFF) tap_q <= tap_q + 8'd1;
          end else begin
            if (tap_q != 8'h00) tap_q <= tap_q - 8'd1;
          end
`endif
        end

        // Out-of-range takes priority over the gap count so an abort never waits out the gap.
        GAP: begin
          if (oor_q) begin
            state  <= FIN;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 4'd1;
          end else if (steps_left == '0) begin
            state  <= FIN;
            done_q <= 1'b1;
          end else if (sat_hit) begin
            state  <= FIN;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else begin
            state  <= MOVE;
            move_q <= 1'b1;
          end
        end

        FIN: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iod_delay_line_ctrl.sv
// Self-checking bench for iod_delay_line_ctrl: directed vector table, reset and saturation
// sequences, and randomized commands against a cycle-arithmetic reference model.
`timescale 1ns/1ps
module tb_iod_delay_line_ctrl;
  localparam int         GAP      = 4;
  localparam logic [7:0] LOAD_VAL = 8'd1;
  localparam int         LIMIT    = 2 + 255 * GAP + 8;
`ifdef IOD_DLY_TAP_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  logic clk  = 1'b0;
  logic arst = 1'b0;
  logic oor  = 1'b0;
  logic mv, dir, ld;

  iod_delay_line_ctrl_if cmd_if ();

  iod_delay_line_ctrl #(.MOVE_GAP(GAP), .LOAD_VAL(LOAD_VAL)) dut (
    .FAB_CLK                   (clk),
    .ARST                      (arst),
    .cmd                       (cmd_if),
    .DELAY_LINE_MOVE_0         (mv),
    .DELAY_LINE_DIRECTION_0    (dir),
    .DELAY_LINE_LOAD_0         (ld),
    .DELAY_LINE_OUT_OF_RANGE_0 (oor)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int obs_mv[$];
  int obs_ld[$];
  int obs_done, obs_err;
  int bad_overlap, bad_dir, bad_busy, stray_err;
  int exp_mv[$];
  int exp_ld[$];
  int exp_done, exp_err;
  int m_tap;

  typedef struct {
    logic [1:0] op;
    int         steps;
    int         oor_after;
    bit         oor_pre;
    int         n_moves;
    int         n_loads;
    int         done;
    int         err;
    int         tap;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: derive pulse cycles (relative to accept cycle T) from the command rules.
  task automatic model(input logic [1:0] op, input int steps, input int oor_after);
    exp_mv.delete();
    exp_ld.delete();
    exp_err = 0;
    if (op == 2'b00) begin
      exp_ld.push_back(1);
      exp_done = 2;
      if (TRACK) m_tap = int'(LOAD_VAL);
    end else if (op == 2'b11) begin
      exp_done = 1;
      exp_err  = 1;
    end else if (steps == 0) begin
      exp_done = 1;
    end else begin
      exp_done = 2 + steps * GAP;
      for (int k = 0; k < steps; k++) begin
        if (TRACK && ((op == 2'b01 && m_tap == 255) || (op == 2'b10 && m_tap == 0))) begin
          exp_done = 2 + k * GAP;
          exp_err  = 1;
          break;
        end
        exp_mv.push_back(2 + k * GAP);
        if (TRACK) m_tap = (op == 2'b01) ? m_tap + 1 : m_tap - 1;
        if (oor_after == k + 1) begin
          exp_done = 2 + k * GAP + 2;
          exp_err  = 1;
          break;
        end
      end
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input int steps, input int oor_after, input bit oor_pre);
    int w;
    obs_mv.delete();
    obs_ld.delete();
    obs_done = -1; obs_err = 0;
    bad_overlap = 0; bad_dir = 0; bad_busy = 0; stray_err = 0;
    w = 0;
    while (cmd_if.CMD_READY !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_cmd", int'(cmd_if.CMD_READY), 1);
    if (oor_pre) oor = 1'b1;
    cmd_if.CMD_VALID = 1'b1;
    cmd_if.CMD_OP    = op;
    cmd_if.CMD_STEPS = 8'(steps);
    for (int c = 1; c <= LIMIT && obs_done < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cmd_if.CMD_VALID = 1'b0;
        if (oor_pre) oor = 1'b0;
      end
      if (mv === 1'b1) begin
        obs_mv.push_back(c);
        if (obs_mv.size() == oor_after) oor = 1'b1;
      end
      if (ld === 1'b1) obs_ld.push_back(c);
      if (mv === 1'b1 && ld === 1'b1) bad_overlap++;
      if ((op == 2'b01 || op == 2'b10) && steps > 0 && dir !== (op == 2'b01)) bad_dir++;
      if (cmd_if.BUSY !== 1'b1 || cmd_if.CMD_READY !== 1'b0) bad_busy++;
      if (cmd_if.DONE === 1'b1) begin
        obs_done = c;
        obs_err  = int'(cmd_if.ERR);
      end else if (cmd_if.ERR === 1'b1) begin
        stray_err++;
      end
    end
    oor = 1'b0;
    @(negedge clk);
    check("done_one_cycle", int'(cmd_if.DONE), 0);
    check("ready_after_fin", int'(cmd_if.CMD_READY), 1);
    check("busy_after_fin", int'(cmd_if.BUSY), 0);
  endtask

  task automatic common_checks(input string tag);
    check({tag, "/move_load_overlap"}, bad_overlap, 0);
    check({tag, "/direction_held"}, bad_dir, 0);
    check({tag, "/busy_not_ready"}, bad_busy, 0);
    check({tag, "/err_without_done"}, stray_err, 0);
  endtask

  task automatic compare_model(input string tag);
    check({tag, "/move_count"}, obs_mv.size(), exp_mv.size());
    for (int i = 0; i < exp_mv.size() && i < obs_mv.size(); i++)
      check({tag, "/move_cycle"}, obs_mv[i], exp_mv[i]);
    check({tag, "/load_count"}, obs_ld.size(), exp_ld.size());
    for (int i = 0; i < exp_ld.size() && i < obs_ld.size(); i++)
      check({tag, "/load_cycle"}, obs_ld[i], exp_ld[i]);
    check({tag, "/done_cycle"}, obs_done, exp_done);
    check({tag, "/err"}, obs_err, exp_err);
    check({tag, "/tap_pos"}, int'(cmd_if.TAP_POS), m_tap);
    common_checks(tag);
  endtask

  initial begin
    int n_done, n_mv, steps, oor_after;
    logic [1:0] op;
    bit pre;

    // op, steps, oor_after, oor_pre, moves, loads, done, err, tap(tracking)
    vecs[0] = '{2'b00, 0, 0, 1'b1, 0, 1,  2, 0, 1};
    vecs[1] = '{2'b01, 3, 0, 1'b0, 3, 0, 14, 0, 4};
    vecs[2] = '{2'b10, 5, 2, 1'b0, 2, 0,  8, 1, 2};
    vecs[3] = '{2'b01, 0, 0, 1'b0, 0, 0,  1, 0, 2};
    vecs[4] = '{2'b10, 0, 0, 1'b1, 0, 0,  1, 0, 2};
    vecs[5] = '{2'b11, 7, 0, 1'b0, 0, 0,  1, 1, 2};
    vecs[6] = '{2'b01, 1, 0, 1'b1, 1, 0,  6, 0, 3};
    vecs[7] = '{2'b10, 2, 0, 1'b0, 2, 0, 10, 0, 1};
    vecs[8] = '{2'b01, 2, 2, 1'b0, 2, 0,  8, 1, 3};
    vecs[9] = '{2'b00, 0, 0, 1'b0, 0, 1,  2, 0, 1};

    cmd_if.CMD_VALID = 1'b0;
    cmd_if.CMD_OP    = 2'b00;
    cmd_if.CMD_STEPS = 8'd0;
    #2 arst = 1'b1;
    repeat (3) @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    check("rst/ready", int'(cmd_if.CMD_READY), 1);
    check("rst/busy", int'(cmd_if.BUSY), 0);
    check("rst/done", int'(cmd_if.DONE), 0);
    check("rst/err", int'(cmd_if.ERR), 0);
    check("rst/move", int'(mv), 0);
    check("rst/load", int'(ld), 0);
    check("rst/dir", int'(dir), 0);
    check("rst/tap", int'(cmd_if.TAP_POS), TRACK ? int'(LOAD_VAL) : 0);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].op, vecs[i].steps, vecs[i].oor_after, vecs[i].oor_pre);
      check("vec/move_count", obs_mv.size(), vecs[i].n_moves);
      for (int k = 0; k < obs_mv.size(); k++) check("vec/move_cycle", obs_mv[k], 2 + k * GAP);
      check("vec/load_count", obs_ld.size(), vecs[i].n_loads);
      for (int k = 0; k < obs_ld.size(); k++) check("vec/load_cycle", obs_ld[k], 1);
      check("vec/done_cycle", obs_done, vecs[i].done);
      check("vec/err", obs_err, vecs[i].err);
      check("vec/tap_pos", int'(cmd_if.TAP_POS), TRACK ? vecs[i].tap : 0);
      common_checks("vec");
    end
    m_tap = TRACK ? int'(LOAD_VAL) : 0;

    // Reset between the first and second move of a 4-step command.
    cmd_if.CMD_VALID = 1'b1;
    cmd_if.CMD_OP    = 2'b01;
    cmd_if.CMD_STEPS = 8'd4;
    @(negedge clk);
    cmd_if.CMD_VALID = 1'b0;
    @(negedge clk);
    check("midrst/first_move", int'(mv), 1);
    repeat (2) @(negedge clk);
    #2 arst = 1'b1;
    #1;
    check("midrst/busy", int'(cmd_if.BUSY), 0);
    check("midrst/done", int'(cmd_if.DONE), 0);
    check("midrst/err", int'(cmd_if.ERR), 0);
    check("midrst/move", int'(mv), 0);
    check("midrst/load", int'(ld), 0);
    check("midrst/dir", int'(dir), 0);
    check("midrst/tap", int'(cmd_if.TAP_POS), TRACK ? int'(LOAD_VAL) : 0);
    @(negedge clk);
    arst = 1'b0;
    #1;
    check("midrst/ready_after_release", int'(cmd_if.CMD_READY), 1);
    n_done = 0;
    n_mv = 0;
    repeat (20) begin
      @(negedge clk);
      if (cmd_if.DONE === 1'b1) n_done++;
      if (mv === 1'b1) n_mv++;
    end
    check("midrst/no_done", n_done, 0);
    check("midrst/no_move", n_mv, 0);
    m_tap = TRACK ? int'(LOAD_VAL) : 0;
    model(2'b01, 2, 0);
    run_cmd(2'b01, 2, 0, 1'b0);
    compare_model("after_rst");

    for (int r = 0; r < 25; r++) begin
      op    = 2'($urandom_range(0, 3));
      steps = int'($urandom_range(0, 10));
      oor_after = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, (steps > 0) ? steps : 1)) : 0;
      pre   = 1'($urandom_range(0, 1));
      model(op, steps, oor_after);
      run_cmd(op, steps, oor_after, pre);
      compare_model("rand");
    end

`ifdef IOD_DLY_TAP_TRACK_EN
    model(2'b00, 0, 0);
    run_cmd(2'b00, 0, 0, 1'b0);
    compare_model("trk/load");
    model(2'b01, 253, 0);
    run_cmd(2'b01, 253, 0, 1'b0);
    compare_model("trk/climb");
    check("trk/tap_254", int'(cmd_if.TAP_POS), 254);
    model(2'b01, 3, 0);
    run_cmd(2'b01, 3, 0, 1'b0);
    compare_model("trk/sat_up");
    check("trk/sat_up_moves", obs_mv.size(), 1);
    check("trk/sat_up_tap", int'(cmd_if.TAP_POS), 255);
    check("trk/sat_up_err", obs_err, 1);
    model(2'b00, 0, 0);
    run_cmd(2'b00, 0, 0, 1'b0);
    compare_model("trk/reload");
    model(2'b10, 3, 0);
    run_cmd(2'b10, 3, 0, 1'b0);
    compare_model("trk/sat_down");
    check("trk/sat_down_tap", int'(cmd_if.TAP_POS), 0);
    check("trk/sat_down_done", obs_done, 6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
